ps2_port: RTL and testbench
===========================

# ps2_port

Synchronous, parametrised PS/2 host port for the CPU I/O space. It receives device frames into a receive FIFO of configurable depth and transmits host-to-device command bytes. It detects framing, parity, overrun and timeout errors, and holds off the device by inhibiting the PS/2 clock while the FIFO is full. Everything runs on one system clock. The PS/2 lines are sampled through synchronisers and a glitch filter.

## Interface
Parameters:
- FIFO_DEPTH, 4: receive FIFO entries; power of two, 2..16.
- FILTER, 4: consecutive identical samples needed to accept a PS/2 line change.
- INHIBIT_CYCLES, 1000: clock-low hold time before a transmit (≥100 µs at the system clock).
- TIMEOUT_CYCLES, 20000: maximum gap between PS/2 clock falling edges inside a frame.

Ports:
- clk, in, 1: system clock; all state changes on the rising edge.
- n_rst, in, 1: synchronous, active-low reset.
- clk_in, in, 1: PS/2 clock line, asynchronous.
- data_in, in, 1: PS/2 data line, asynchronous.
- n_clk_out, out, 1: 1 pulls the PS/2 clock low; 0 releases it.
- n_data_out, out, 1: 1 pulls the PS/2 data low; 0 releases it.
- d_in, in, 8: CPU write data.
- d_out, out, 8: CPU read data.
- d_oe, out, 1: d_out valid; equals ~n_sel & ~n_oe.
- n_sel, in, 1: chip select, active low.
- n_oe, in, 1: read strobe, active low.
- n_we, in, 1: write strobe, active low.
- a, in, 2: register select. 0 = data, 1 = status, 2 = control.
- rdy, out, 1: 0 stalls the CPU access.

## Operation
Input conditioning:
- 2-FF synchroniser on each line, then a FILTER-sample agreement filter.
- A filtered clock 1→0 transition is a "fall" event.

Receiver FSM (RX_IDLE, RX_BITS):
- RX_IDLE → RX_BITS on a fall with data = 0 (start bit).
- A fall with data = 1 in RX_IDLE is ignored.
- RX_BITS samples 10 more falls, in order: data bits LSB first, odd parity, stop.
- After the 11th bit:
  - start = 0, odd parity OK, stop = 1, FIFO not full: push the byte.
  - FIFO full: drop the byte, set OVR.
  - Parity or stop bad: drop the byte, set FERR.
- The FSM then returns to RX_IDLE.
- Receiver is held in RX_IDLE while the transmitter is not idle.

Flow control:
- While the FIFO is full and the receiver is in RX_IDLE, n_clk_out = 1.
- Clock is released on the cycle after a pop makes the FIFO not full.

Transmitter FSM (TX_IDLE, TX_INH, TX_BITS, TX_ACK):
- A data write in TX_IDLE latches the byte and its odd parity bit, sets BUSY, and enters TX_INH.
- TX_INH: n_clk_out = 1 for INHIBIT_CYCLES. Then n_data_out = 1 (start bit), clock released, enter TX_BITS.
- TX_BITS: on each fall, drive the next bit: 8 data bits LSB first, then parity, then stop (released). Bit value b is driven as n_data_out = ~b.
- After the stop bit, enter TX_ACK. The next fall samples data: 0 sets ACK, 1 sets TERR.
- TX_ACK then returns to TX_IDLE and clears BUSY.

Timeout:
- The counter restarts at each fall.
- TIMEOUT_CYCLES without a fall in RX_BITS → RX_IDLE, set FERR.
- TIMEOUT_CYCLES without a fall in TX_BITS or TX_ACK → release both lines, TX_IDLE, set TERR.

Registers:
- Read a=0: FIFO head; 0x00 when empty.
- Read a=1 (status): {2'b0, TERR, ACK, BUSY, OVR, FERR, AVAIL}. AVAIL = FIFO not empty.
- Read a=3: 0x00.
- Write a=0: transmit the byte.
- Write a=2, bit0 = 1: clear FERR, OVR, ACK and TERR.
- Write a=2, bit1 = 1: flush the FIFO.
- Write a=1 or a=3: ignored.

Reset values:
- n_clk_out = 0, n_data_out = 0, rdy = 1, d_out = 0x00.
- All flags 0, FIFO empty, both FSMs idle, counters 0.

## Timing
Read access:
- d_out is combinational from a and the FIFO head / flags during the access.
- The FIFO pops on the first cycle after a data read access ends, where an access is n_sel = 0, n_oe = 0, a = 0. Exactly one pop per access, none when empty.

Write access:
- Takes effect on the first cycle with n_sel = 0, n_we = 0 and rdy = 1. Once per access.
- A data write while BUSY drives rdy = 0 until TX_IDLE; the write is then accepted.

Line latency:
- Line change to fall event: 2 + FILTER cycles.
- Fall to FIFO push and AVAIL = 1: 1 cycle.

Simultaneous events:
- Push and pop in the same cycle: count unchanged; valid even when full.
- Clear and flag set in the same cycle: the set wins.
- Flush and push in the same cycle: the FIFO ends empty.

Reset mid-frame:
- Frame abandoned, lines released next cycle.
- The partial frame is never pushed.

## Test plan
- Receive byte: device sends 0x1C with parity 0 → status reads 0x01, data read returns 0x1C, status then reads 0x00.
- Parity error: device sends 0x1C with parity 1 → FERR set, AVAIL = 0. Control write 0x01 → status reads 0x00.
- Flow control (FIFO_DEPTH = 4): 4 frames → n_clk_out = 1. Model ignores the inhibit and sends a 5th frame → OVR set, FIFO holds the first 4 bytes. One read → n_clk_out = 0.
- Transmit 0xED: n_clk_out = 1 for INHIBIT_CYCLES, then start bit, bits 1,0,1,1,0,1,1,1, parity 1, stop. Model ACKs → status reads 0x10; BUSY = 1 during the transfer.
- Timeout / NACK:
  - Model stops clocking after 5 bits in either direction → FERR or TERR after TIMEOUT_CYCLES, lines released.
  - Model NACKs → TERR set.
- Stall and reset: a second data write while BUSY holds rdy = 0 until TX_IDLE. n_rst low mid-receive → all outputs at reset values next cycle, no push.

Source files
------------

// File: rtl/ps2_port.sv
// PS/2 host port: conditioned line inputs, receive FIFO with clock-inhibit flow control,
// host-to-device transmitter, and a small CPU register window (data/status/control).
//
// state    | meaning
// RX_IDLE  | waiting for a start bit (fall with data low)
// RX_BITS  | shifting in 8 data bits, parity and stop on successive falls
// TX_IDLE  | no transmit pending
// TX_INH   | holding the PS/2 clock low before requesting to send
// TX_BITS  | start bit driven; next bit driven on each device clock fall
// TX_ACK   | stop released; next fall samples the device acknowledge
module ps2_port #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER         = 4,
  parameter int INHIBIT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_in,
  input  logic       data_in,
  output logic       n_clk_out,
  output logic       n_data_out,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       n_sel,
  input  logic       n_oe,
  input  logic       n_we,
  input  logic [1:0] a,
  output logic       rdy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_INH, TX_BITS, TX_ACK} tx_state_t;

  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] clk_cnt, data_cnt;
  logic          clk_f, clk_f_d, data_f, fall;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, rx_push, pop;

  logic [9:0]    rx_sr, frame;
  logic [3:0]    rx_cnt;
  logic          rx_done, frame_ok, rx_timeout;

  logic [9:0]    tx_sr;
  logic [3:0]    tx_cnt;
  logic [IW-1:0] inh_cnt;
  logic          tx_drv, tx_idle, tx_timeout, inh_done;

  logic [TW-1:0] to_cnt;
  logic          to_active, timeout;

  logic          ferr, ovr, ack, terr;
  logic          ferr_set, ovr_set, ack_set, terr_set;
  logic          wr_req, we_done, wr_stb, tx_start, clr_flags, flush;
  logic          rd_acc, rd_acc_q;
  logic [7:0]    status;

  // Line conditioning: a new level is accepted only after FILTER agreeing samples.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_cnt   <= '0;
      data_cnt  <= '0;
      clk_f     <= 1'b1;
      clk_f_d   <= 1'b1;
      data_f    <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], clk_in};
      data_sync <= {data_sync[0], data_in};
      clk_f_d   <= clk_f;
      if (clk_sync[1] != clk_f) begin
        if (clk_cnt == FW'(FILTER - 1)) begin
          clk_f   <= clk_sync[1];
          clk_cnt <= '0;
        end else begin
          clk_cnt <= clk_cnt + FW'(1);
        end
      end else begin
        clk_cnt <= '0;
      end
      if (data_sync[1] != data_f) begin
        if (data_cnt == FW'(FILTER - 1)) begin
          data_f   <= data_sync[1];
          data_cnt <= '0;
        end else begin
          data_cnt <= data_cnt + FW'(1);
        end
      end else begin
        data_cnt <= '0;
      end
    end
  end

  assign fall = clk_f_d & ~clk_f;

  // CPU bus decode
  assign tx_idle   = (tx_state == TX_IDLE);
  assign wr_req    = ~n_sel & ~n_we;
  assign rdy       = ~(wr_req & ~we_done & (a == 2'd0) & ~tx_idle);
  assign wr_stb    = wr_req & ~we_done & rdy;
  assign tx_start  = wr_stb & (a == 2'd0);
  assign clr_flags = wr_stb & (a == 2'd2) & d_in[0];
  assign flush     = wr_stb & (a == 2'd2) & d_in[1];
  assign rd_acc    = ~n_sel & ~n_oe & (a == 2'd0);
  assign pop       = rd_acc_q & ~rd_acc & ~empty;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      we_done  <= 1'b0;
      rd_acc_q <= 1'b0;
    end else begin
      rd_acc_q <= rd_acc;
      if (!wr_req)     we_done <= 1'b0;
      else if (wr_stb) we_done <= 1'b1;
    end
  end

  // Receive FIFO
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rx_push) mem[wr_ptr] <= frame[7:0];
  end

  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rx_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(rx_push) - CW'(pop);
    end
  end

  // Frame check; a pop in the same cycle frees the slot for the push.
  assign frame      = {data_f, rx_sr[9:1]};
  assign frame_ok   = frame[9] & (^frame[8:0]);
  assign rx_done    = (rx_state == RX_BITS) & fall & (rx_cnt == 4'd9) & tx_idle;
  assign rx_timeout = (rx_state == RX_BITS) & timeout;
  assign rx_push    = rx_done & frame_ok & (~full | pop);
  assign ovr_set    = rx_done & frame_ok & full & ~pop;
  assign ferr_set   = (rx_done & ~frame_ok) | (rx_timeout & tx_idle);

  always_ff @(posedge clk) begin
    if (!n_rst) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!tx_idle) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE: if (fall && !data_f) rx_next = RX_BITS;
        RX_BITS: if (rx_timeout || (fall && rx_cnt == 4'd9)) rx_next = RX_IDLE;
        default: rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_sr  <= '0;
      rx_cnt <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= '0;
    end else if (fall) begin
      rx_sr  <= frame;
      rx_cnt <= rx_cnt + 4'd1;
    end
  end

  // Transmitter
  assign inh_done   = (tx_state == TX_INH) & (inh_cnt == '0);
  assign tx_timeout = ((tx_state == TX_BITS) | (tx_state == TX_ACK)) & timeout;
  assign ack_set    = (tx_state == TX_ACK) & ~tx_timeout & fall & ~data_f;
  assign terr_set   = ((tx_state == TX_ACK) & fall & data_f) | tx_timeout;

  always_ff @(posedge clk) begin
    if (!n_rst) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_start) tx_next = TX_INH;
      TX_INH:  if (inh_done) tx_next = TX_BITS;
      TX_BITS: begin
        if (tx_timeout)                     tx_next = TX_IDLE;
        else if (fall && tx_cnt == 4'd9)    tx_next = TX_ACK;
      end
      TX_ACK:  if (tx_timeout || fall) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      tx_sr   <= '0;
      tx_cnt  <= '0;
      inh_cnt <= '0;
      tx_drv  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_drv <= 1'b0;
          if (tx_start) begin
            tx_sr   <= {1'b1, ~^d_in, d_in};
            tx_cnt  <= '0;
            inh_cnt <= IW'(INHIBIT_CYCLES - 1);
          end
        end
        TX_INH: begin
          if (inh_done) tx_drv <= 1'b1;
          else          inh_cnt <= inh_cnt - IW'(1);
        end
        TX_BITS: begin
          if (tx_timeout) begin
            tx_drv <= 1'b0;
          end else if (fall) begin
            tx_drv <= ~tx_sr[0];
            tx_sr  <= {1'b0, tx_sr[9:1]};
            tx_cnt <= tx_cnt + 4'd1;
          end
        end
        default: tx_drv <= 1'b0;
      endcase
    end
  end

  // Inter-fall watchdog, reloaded on every fall and when the transmit starts clocking.
  assign to_active = (rx_state == RX_BITS) | (tx_state == TX_BITS) | (tx_state == TX_ACK);
  assign timeout   = to_active & ~fall & (to_cnt == '0);

  always_ff @(posedge clk) begin
    if (!n_rst)                        to_cnt <= '0;
    else if (fall || inh_done)         to_cnt <= TW'(TIMEOUT_CYCLES - 1);
    else if (to_active && to_cnt != '0) to_cnt <= to_cnt - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ferr <= 1'b0;
      ovr  <= 1'b0;
      ack  <= 1'b0;
      terr <= 1'b0;
    end else begin
      ferr <= ferr_set | (ferr & ~clr_flags);
      ovr  <= ovr_set  | (ovr  & ~clr_flags);
      ack  <= ack_set  | (ack  & ~clr_flags);
      terr <= terr_set | (terr & ~clr_flags);
    end
  end

  assign n_clk_out  = (tx_state == TX_INH) | (full & (rx_state == RX_IDLE) & tx_idle);
  assign n_data_out = tx_drv;
  assign d_oe       = ~n_sel & ~n_oe;
  assign status     = {2'b00, terr, ack, ~tx_idle, ovr, ferr, ~empty};

  always_comb begin
    d_out = 8'h00;
    if (d_oe) begin
      case (a)
        2'd0:    d_out = empty ? 8'h00 : mem[rd_ptr];
        2'd1:    d_out = status;
        default: d_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_port.sv
// Bench for ps2_port: a PS/2 device model on wired-AND lines plus a CPU bus driver;
// received bytes and transmitted bits are tracked in scoreboard queues.
module tb_ps2_port;
  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int INH   = 100;
  localparam int TMO   = 400;
  localparam int H     = 20;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dev_clk = 1'b1, dev_data = 1'b1, ignore_inh = 1'b0;
  logic       clk_in_w, data_in_w;
  logic       n_clk_out, n_data_out, d_oe, rdy;
  logic [7:0] d_in = 8'h00, d_out;
  logic       n_sel = 1'b1, n_oe = 1'b1, n_we = 1'b1;
  logic [1:0] a = 2'd0;

  int         n_cmp = 0, n_err = 0;
  logic [7:0] rx_q[$];
  logic       tx_q[$];

  assign clk_in_w  = dev_clk & (ignore_inh | ~n_clk_out);
  assign data_in_w = dev_data & ~n_data_out;

  ps2_port #(.FIFO_DEPTH(DEPTH), .FILTER(FILT), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .n_rst(n_rst), .clk_in(clk_in_w), .data_in(data_in_w),
    .n_clk_out(n_clk_out), .n_data_out(n_data_out), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .n_sel(n_sel), .n_oe(n_oe), .n_we(n_we), .a(a), .rdy(rdy));

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] addr, output logic [7:0] val);
    @(negedge clk);
    n_sel = 1'b0; n_oe = 1'b0; a = addr;
    @(negedge clk);
    val = d_out;
    n_sel = 1'b1; n_oe = 1'b1;
    cyc(2);
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] val);
    int t;
    @(posedge clk);
    @(negedge clk);
    n_sel = 1'b0; n_we = 1'b0; a = addr; d_in = val;
    t = 0;
    while (rdy !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 5000) begin
      n_err++;
      $display("FAIL write_rdy got rdy=%b want 1 within 5000 cycles", rdy);
    end
    @(posedge clk);
    #1 n_sel = 1'b1; n_we = 1'b1;
  endtask

  task automatic dev_send(input logic [7:0] b, input logic bad_par, input int nbits,
                          input logic expect_push);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data = fr[i];
      cyc(H);
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    cyc(H);
    if (expect_push) rx_q.push_back(b);
  endtask

  task automatic tx_expect(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(~^b);
    tx_q.push_back(1'b1);
  endtask

  task automatic dev_recv(input int nbits, input logic give_ack);
    logic exp;
    for (int i = 0; i < nbits; i++) begin
      cyc(H);
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      cyc(2);
      exp = (tx_q.size() > 0) ? tx_q.pop_front() : 1'b1;
      n_cmp++;
      if (data_in_w !== exp) begin
        n_err++;
        $display("FAIL tx_bit%0d got %b want %b", i, data_in_w, exp);
      end
    end
    if (nbits == 10) begin
      cyc(H);
      dev_data = ~give_ack;
      cyc(H);
      dev_clk = 1'b0;
      cyc(H);
      dev_clk = 1'b1;
      dev_data = 1'b1;
      cyc(H);
    end
  endtask

  task automatic wait_inhibit(output int n);
    n = 0;
    @(negedge clk);
    while (n_clk_out === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    n_rst = 1'b0;
    cyc(3);
    n_cmp++;
    if ({n_clk_out, n_data_out, rdy, d_oe, d_out} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL reset_outputs got %b%b%b%b %h want 0010 00",
               n_clk_out, n_data_out, rdy, d_oe, d_out);
    end
    n_rst = 1'b1;
    cyc(2);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL reset_status got %h want 00", v); end
    cpu_read(2'd0, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", v); end
  endtask

  task automatic test_receive;
    logic [7:0] v, e;
    dev_send(8'h1C, 1'b0, 11, 1'b1);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h01) begin n_err++; $display("FAIL rx_status got %h want 01", v); end
    cpu_read(2'd0, v);
    e = rx_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_err++; $display("FAIL rx_data got %h want %h", v, e); end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL rx_status_after got %h want 00", v); end
  endtask

  task automatic test_parity;
    logic [7:0] v;
    dev_send(8'h1C, 1'b1, 11, 1'b0);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h02) begin n_err++; $display("FAIL parity_status got %h want 02", v); end
    cpu_write(2'd2, 8'h01);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL parity_clear got %h want 00", v); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v, e;
    for (int i = 0; i < 3; i++) dev_send(8'($urandom_range(0, 255)), 1'b0, 11, 1'b1);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h01) begin n_err++; $display("FAIL b2b_status got %h want 01", v); end
    while (rx_q.size() > 0) begin
      cpu_read(2'd0, v);
      e = rx_q.pop_front();
      n_cmp++;
      if (v !== e) begin n_err++; $display("FAIL b2b_data got %h want %h", v, e); end
    end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL b2b_empty got %h want 00", v); end
  endtask

  task automatic test_flush;
    logic [7:0] v;
    dev_send(8'hA1, 1'b0, 11, 1'b1);
    dev_send(8'h5E, 1'b0, 11, 1'b1);
    cpu_write(2'd2, 8'h02);
    rx_q.delete();
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL flush_status got %h want 00", v); end
  endtask

  task automatic test_flow;
    logic [7:0] v, e;
    for (int i = 0; i < DEPTH; i++) dev_send(8'h30 + 8'(i), 1'b0, 11, 1'b1);
    n_cmp++;
    if (n_clk_out !== 1'b1) begin n_err++; $display("FAIL flow_inhibit got %b want 1", n_clk_out); end
    ignore_inh = 1'b1;
    dev_send(8'hEE, 1'b0, 11, 1'b0);
    ignore_inh = 1'b0;
    cyc(10);
    n_cmp++;
    if (n_clk_out !== 1'b1) begin n_err++; $display("FAIL flow_still_inhibit got %b want 1", n_clk_out); end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h05) begin n_err++; $display("FAIL flow_ovr_status got %h want 05", v); end
    cpu_read(2'd0, v);
    e = rx_q.pop_front();
    n_cmp++;
    if (v !== e) begin n_err++; $display("FAIL flow_data got %h want %h", v, e); end
    n_cmp++;
    if (n_clk_out !== 1'b0) begin n_err++; $display("FAIL flow_release got %b want 0", n_clk_out); end
    while (rx_q.size() > 0) begin
      cpu_read(2'd0, v);
      e = rx_q.pop_front();
      n_cmp++;
      if (v !== e) begin n_err++; $display("FAIL flow_data got %h want %h", v, e); end
    end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h04) begin n_err++; $display("FAIL flow_drained got %h want 04", v); end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_transmit;
    logic [7:0] v;
    int n;
    tx_expect(8'hED);
    cpu_write(2'd0, 8'hED);
    wait_inhibit(n);
    n_cmp++;
    if (n != INH) begin n_err++; $display("FAIL tx_inhibit_len got %0d want %0d", n, INH); end
    n_cmp++;
    if (n_data_out !== 1'b1) begin n_err++; $display("FAIL tx_start_bit got %b want 1", n_data_out); end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h08) begin n_err++; $display("FAIL tx_busy got %h want 08", v); end
    dev_recv(10, 1'b1);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h10) begin n_err++; $display("FAIL tx_ack_status got %h want 10", v); end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_nack;
    logic [7:0] v;
    int n;
    tx_expect(8'h5A);
    cpu_write(2'd0, 8'h5A);
    wait_inhibit(n);
    dev_recv(10, 1'b0);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h20) begin n_err++; $display("FAIL nack_status got %h want 20", v); end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_timeout_rx;
    logic [7:0] v;
    dev_send(8'h33, 1'b0, 5, 1'b0);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL rx_to_early got %h want 00", v); end
    cyc(TMO + 20);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h02) begin n_err++; $display("FAIL rx_to_status got %h want 02", v); end
    n_cmp++;
    if ({n_clk_out, n_data_out} !== 2'b00) begin
      n_err++; $display("FAIL rx_to_lines got %b%b want 00", n_clk_out, n_data_out);
    end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_timeout_tx;
    logic [7:0] v;
    int n;
    tx_expect(8'hA5);
    cpu_write(2'd0, 8'hA5);
    wait_inhibit(n);
    dev_recv(5, 1'b0);
    tx_q.delete();
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h08) begin n_err++; $display("FAIL tx_to_early got %h want 08", v); end
    cyc(TMO + 20);
    n_cmp++;
    if ({n_clk_out, n_data_out} !== 2'b00) begin
      n_err++; $display("FAIL tx_to_lines got %b%b want 00", n_clk_out, n_data_out);
    end
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h20) begin n_err++; $display("FAIL tx_to_status got %h want 20", v); end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_stall;
    logic [7:0] v;
    int n;
    tx_expect(8'h11);
    cpu_write(2'd0, 8'h11);
    cyc(2);
    n_sel = 1'b0; n_we = 1'b0; a = 2'd0; d_in = 8'h22;
    @(negedge clk);
    n_cmp++;
    if (rdy !== 1'b0) begin n_err++; $display("FAIL stall_rdy_inh got %b want 0", rdy); end
    wait_inhibit(n);
    n_cmp++;
    if (rdy !== 1'b0) begin n_err++; $display("FAIL stall_rdy_bits got %b want 0", rdy); end
    dev_recv(10, 1'b1);
    n_cmp++;
    if ({rdy, n_clk_out} !== 2'b11) begin
      n_err++; $display("FAIL stall_accept got rdy=%b inh=%b want 11", rdy, n_clk_out);
    end
    @(negedge clk);
    n_sel = 1'b1; n_we = 1'b1;
    tx_expect(8'h22);
    wait_inhibit(n);
    dev_recv(10, 1'b1);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h10) begin n_err++; $display("FAIL stall_second got %h want 10", v); end
    cpu_write(2'd2, 8'h01);
  endtask

  task automatic test_reset_mid;
    logic [7:0] v;
    dev_send(8'h44, 1'b0, 4, 1'b0);
    n_rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({n_clk_out, n_data_out, rdy, d_out} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_err++; $display("FAIL rst_rx_outputs got %b%b%b %h want 001 00", n_clk_out, n_data_out, rdy, d_out);
    end
    n_rst = 1'b1;
    cyc(50);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL rst_rx_nopush got %h want 00", v); end
    cpu_write(2'd0, 8'h77);
    cyc(10);
    n_cmp++;
    if (n_clk_out !== 1'b1) begin n_err++; $display("FAIL rst_tx_inh got %b want 1", n_clk_out); end
    n_rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({n_clk_out, n_data_out, rdy} !== 3'b001) begin
      n_err++; $display("FAIL rst_tx_outputs got %b%b%b want 001", n_clk_out, n_data_out, rdy);
    end
    n_rst = 1'b1;
    cyc(20);
    cpu_read(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_err++; $display("FAIL rst_tx_status got %h want 00", v); end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_parity();
    test_back_to_back();
    test_flush();
    test_flow();
    test_transmit();
    test_nack();
    test_timeout_rx();
    test_timeout_tx();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
